aes_block_serializer: RTL and testbench

//  Consumer for the aes256_fifo output port. Accepts 128-bit cipher/plain blocks over

---
 rtl/aes_pkg.sv | 11 +
 rtl/aes_block_serializer.sv | 75 +++++++
 tb/tb_aes_block_serializer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES block width, serializer state encoding and keep helper
package aes_pkg;
  localparam int AES_BLK_W = 128;
  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;
  // Byte enables for a word holding min(rem,bpw) bytes; first byte sits in the top bit.
  function automatic logic [7:0] keep_from_rem(input logic [31:0] rem, input int bpw);
    keep_from_rem = '0;
    for (int j = 0; j < 8; j++)
      if (j < bpw && 32'(j) < rem) keep_from_rem[3'(bpw - 1 - j)] = 1'b1;
  endfunction
endpackage

// File: rtl/aes_block_serializer.sv
// aes_block_serializer: serialises 128-bit AES blocks into a keep/last word stream
module aes_block_serializer
  import aes_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [AES_BLK_W-1:0]  blk_data,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [WORD_W-1:0]     word_data,
  output logic [WORD_W/8-1:0]   word_keep,
  output logic                  word_last,
  output logic                  busy,
  output logic                  done
);
  localparam int BPW  = WORD_W / 8;
  localparam int WPB  = AES_BLK_W / WORD_W;
  localparam int WI_W = $clog2(WPB);
  state_t               state;
  logic [LEN_W-1:0]     rem;
  logic [AES_BLK_W-1:0] hold;
  logic [WI_W-1:0]      widx;
  logic                 emit, blk_end;
  always_comb begin
    emit       = state == EMIT;
    cfg_ready  = state == IDLE;
    busy       = !cfg_ready;
    word_valid = emit;
    word_last  = emit && rem <= LEN_W'(BPW);
    word_keep  = emit ? BPW'(keep_from_rem(32'(rem), BPW)) : '0;
    word_data  = emit ? WORD_W'(hold >> (WORD_W * (WPB - 1 - int'(widx)))) : '0;
    // Accepting the next block as the last word of this one leaves keeps the stream gapless.
    blk_end    = emit && word_ready && !word_last && widx == WI_W'(WPB - 1);
    blk_ready  = state == LOAD || blk_end;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      hold  <= '0;
      widx  <= '0;
      done  <= 1'b0;
    end else begin
      done <= (cfg_valid && cfg_ready && cfg_len == '0) || (word_valid && word_ready && word_last);
      if (cfg_valid && cfg_ready && cfg_len != '0) begin
        rem   <= cfg_len;
        state <= LOAD;
      end
      if (state == LOAD && blk_valid) begin
        hold  <= blk_data;
        widx  <= '0;
        state <= EMIT;
      end
      if (emit && word_ready) begin
        rem  <= rem - (word_last ? rem : LEN_W'(BPW));
        widx <= widx + 1'b1;
        if (word_last) state <= IDLE;
        else if (widx == WI_W'(WPB - 1)) begin
          if (blk_valid) begin
            hold <= blk_data;
            widx <= '0;
          end else state <= LOAD;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_block_serializer.sv
// tb_aes_block_serializer: scoreboard bench for the AES block serializer
module tb_aes_block_serializer;
  logic         clk = 1'b0, rst = 1'b1;
  logic         cfg_valid = 1'b0, cfg_ready;
  logic [15:0]  cfg_len = '0;
  logic         blk_valid = 1'b0, blk_ready;
  logic [127:0] blk_data = '0;
  logic         word_valid, word_ready = 1'b1, word_last, busy, done;
  logic [31:0]  word_data;
  logic [3:0]   word_keep;
  int           checks = 0, errors = 0;
  logic [36:0]  exp_q[$];
  logic [36:0]  exp_w;
  localparam logic [127:0] B1  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] B2A = 128'h01020304_05060708_090a0b0c_0d0e0f10;
  localparam logic [127:0] B2B = 128'ha0a1a2a3_b0b1b2b3_c0c1c2c3_d0d1d2d3;
  localparam logic [127:0] B3  = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
  localparam logic [127:0] B4A = 128'h10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [127:0] B4B = 128'h20212223_24252627_28292a2b_2c2d2e2f;
  localparam logic [127:0] B6  = 128'h55aa55aa_66bb66bb_77cc77cc_88dd88dd;

  always #5 clk = ~clk;

  aes_block_serializer #(.WORD_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .word_keep(word_keep), .word_last(word_last), .busy(busy), .done(done)
  );

  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_extra got %h keep %h last %b expected none", word_data, word_keep, word_last);
      end else begin
        exp_w = exp_q.pop_front();
        if ({word_data, word_keep, word_last} !== exp_w) begin
          errors++;
          $display("FAIL word got %h keep %h last %b expected %h keep %h last %b",
                   word_data, word_keep, word_last, exp_w[36:5], exp_w[4:1], exp_w[0]);
        end
      end
    end
  end

  function automatic void push(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_q.push_back({d, k, l});
  endfunction

  task automatic send_cfg(input logic [15:0] len);
    cfg_valid = 1'b1;
    cfg_len   = len;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic send_blk(input logic [127:0] d);
    logic hs;
    int   n;
    hs = 1'b0;
    n  = 0;
    blk_valid = 1'b1;
    blk_data  = d;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = blk_ready;
      @(posedge clk);
      #1 n++;
    end
    blk_valid = 1'b0;
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL blk_handshake got timeout expected blk_ready within 100 cycles");
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout got %b expected 1", done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL words_missing got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cfg_ready, blk_ready, word_valid, word_data, word_keep, word_last, busy, done} !== {1'b1, 41'b0}) begin
      errors++;
      $display("FAIL reset_outputs got cfg_ready %b blk_ready %b valid %b data %h keep %h last %b busy %b done %b expected 1 and all zero",
               cfg_ready, blk_ready, word_valid, word_data, word_keep, word_last, busy, done);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_full_block(input logic [127:0] b);
    logic [127:0] bv;
    bv = b;
    push(bv[127:96], 4'hf, 1'b0);
    push(bv[95:64], 4'hf, 1'b0);
    push(bv[63:32], 4'hf, 1'b0);
    push(bv[31:0], 4'hf, 1'b1);
    send_cfg(16);
    send_blk(b);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (word_valid !== 1'b1 || word_last !== (i == 4)) begin
        errors++;
        $display("FAIL full_word%0d got valid %b last %b expected valid 1 last %b", i, word_valid, word_last, i == 4);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || word_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_done got done %b valid %b expected done 1 valid 0", done, word_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL full_done_pulse got %b expected 0", done);
    end
  endtask

  task automatic test_back_to_back();
    push(32'h01020304, 4'hf, 1'b0);
    push(32'h05060708, 4'hf, 1'b0);
    push(32'h090a0b0c, 4'hf, 1'b0);
    push(32'h0d0e0f10, 4'hf, 1'b0);
    push(32'ha0a1a2a3, 4'hf, 1'b1);
    send_cfg(20);
    send_blk(B2A);
    fork
      send_blk(B2B);
      for (int i = 1; i <= 5; i++) begin
        @(negedge clk);
        checks++;
        if (word_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_gap word%0d got valid %b expected 1", i, word_valid);
        end
      end
    join
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || blk_ready !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end got done %b blk_ready %b cfg_ready %b expected 1 0 1", done, blk_ready, cfg_ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_pending got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_partial();
    push(32'hdeadbeef, 4'hf, 1'b0);
    push(32'hcafef00d, 4'hc, 1'b1);
    send_cfg(6);
    send_blk(B3);
    wait_done();
  endtask

  task automatic test_stall();
    logic        stall_prev, seen;
    logic [36:0] saved;
    stall_prev = 1'b0;
    seen       = 1'b0;
    saved      = '0;
    push(32'h10111213, 4'hf, 1'b0);
    push(32'h14151617, 4'hf, 1'b0);
    push(32'h18191a1b, 4'hf, 1'b0);
    push(32'h1c1d1e1f, 4'hf, 1'b0);
    push(32'h20212223, 4'hf, 1'b0);
    push(32'h24252627, 4'hf, 1'b0);
    push(32'h28292a2b, 4'hf, 1'b0);
    push(32'h2c2d2e2f, 4'hf, 1'b1);
    send_cfg(32);
    fork
      begin
        send_blk(B4A);
        send_blk(B4B);
      end
      for (int n = 0; n < 200 && !seen; n++) begin
        @(posedge clk);
        #1 word_ready = ~word_ready;
        @(negedge clk);
        if (stall_prev) begin
          checks++;
          if (word_valid !== 1'b1 || {word_data, word_keep, word_last} !== saved) begin
            errors++;
            $display("FAIL stall_stable got valid %b %h/%h/%b expected valid 1 %h/%h/%b",
                     word_valid, word_data, word_keep, word_last, saved[36:5], saved[4:1], saved[0]);
          end
        end
        stall_prev = word_valid && !word_ready;
        saved      = {word_data, word_keep, word_last};
        seen       = done;
      end
    join
    word_ready = 1'b1;
    checks++;
    if (!seen || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_complete got done_seen %b pending %0d expected 1 and 0", seen, exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    send_cfg(0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cfg_ready !== 1'b1 || word_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len got done %b cfg_ready %b valid %b busy %b expected 1 1 0 0", done, cfg_ready, word_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || word_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_after got done %b valid %b expected 0 0", done, word_valid);
    end
  endtask

  task automatic test_reset_mid();
    push(32'h55aa55aa, 4'hf, 1'b0);
    push(32'h66bb66bb, 4'hf, 1'b0);
    send_cfg(32);
    send_blk(B6);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid got valid %b busy %b cfg_ready %b pending %0d expected 0 0 1 0",
               word_valid, busy, cfg_ready, exp_q.size());
    end
    @(posedge clk);
    #1 test_full_block(B1);
  endtask

  initial begin
    test_reset();
    test_full_block(B1);
    test_back_to_back();
    test_partial();
    test_stall();
    test_zero_len();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
